// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_arbiter
// Description : Round-robin arbiter sharing one i2cmaster between NREQ clients.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter #(
    parameter int NREQ      = 4,
    parameter int EN_CYCLES = 5,
    parameter int START_TO  = 64,
    parameter int XFER_TO   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_rw,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     err,
    output logic [7:0]          rd_data,
    output logic                busy,
    output logic [6:0]          m_addr,
    output logic [7:0]          m_data_in,
    output logic                m_rw,
    output logic                m_enable,
    input  logic [7:0]          m_data_out,
    input  logic                m_ready
);

    localparam int c_PTR_W = $clog2(NREQ);
    localparam int c_MAX_T = (XFER_TO > START_TO) ? XFER_TO : START_TO;
    localparam int c_CNT_W = $clog2(((c_MAX_T > EN_CYCLES) ? c_MAX_T : EN_CYCLES) + 1);

    localparam logic [c_CNT_W-1:0] c_EN_LAST    = c_CNT_W'(EN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_TO - 1);
    localparam logic [c_CNT_W-1:0] c_XFER_LAST  = c_CNT_W'(XFER_TO - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST   = c_PTR_W'(NREQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_FINISH     = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_win;
    logic [c_CNT_W-1:0]   r_cnt;

    int                   w_idx;
    logic [c_PTR_W-1:0]   w_sel;
    logic [c_PTR_W-1:0]   w_win;
    logic [NREQ-1:0]      w_win_oh;
    logic [6:0]           w_addr;
    logic [7:0]           w_data;
    logic                 w_rw;

    // Scan from the far end back toward r_ptr so the closest set bit wins last.
    always_comb begin
        w_idx = 0;
        w_sel = '0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_sel = c_PTR_W'(w_idx);
            if (req[w_sel]) begin
                w_win = w_sel;
            end
        end
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
        w_addr = '0;
        w_data = '0;
        w_rw   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_oh[i]) begin
                w_addr = req_addr[7*i +: 7];
                w_data = req_data[8*i +: 8];
                w_rw   = req_rw[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            m_enable  <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (m_ready && |req) begin
                        gnt       <= w_win_oh;
                        r_win     <= w_win;
                        m_addr    <= w_addr;
                        m_data_in <= w_data;
                        m_rw      <= w_rw;
                        busy      <= 1'b1;
                        m_enable  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (r_cnt == c_EN_LAST) begin
                        m_enable <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= ST_WAIT_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_START: begin
                    if (!m_ready) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == c_START_LAST) begin
                        err     <= gnt;
                        r_state <= ST_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (m_ready) begin
                        if (m_rw) begin
                            rd_data <= m_data_out;
                        end
                        done    <= gnt;
                        r_state <= ST_FINISH;
                    end else if (r_cnt == c_XFER_LAST) begin
                        err     <= gnt;
                        r_state <= ST_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    r_ptr   <= (r_win == c_PTR_LAST) ? '0 : r_win + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_master_arbiter
// Description : Self-checking bench with a timestamp-based transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

    localparam int NREQ      = 4;
    localparam int EN_CYCLES = 5;
    localparam int START_TO  = 64;
    localparam int XFER_TO   = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req = '0;
    logic [27:0]     req_addr = '0;
    logic [31:0]     req_data = '0;
    logic [3:0]      req_rw = '0;
    logic [3:0]      gnt, done, err;
    logic [7:0]      rd_data;
    logic            busy;
    logic [6:0]      m_addr;
    logic [7:0]      m_data_in;
    logic            m_rw, m_enable;
    logic [7:0]      m_data_out = '0;
    logic            m_ready = 1'b1;

    i2c_master_arbiter #(.NREQ(NREQ), .EN_CYCLES(EN_CYCLES), .START_TO(START_TO), .XFER_TO(XFER_TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .busy(busy), .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw),
        .m_enable(m_enable), .m_data_out(m_data_out), .m_ready(m_ready)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Master emulator: mode 0 normal, 1 ready stuck high, 2 never completes.
    int         sl_mode = 0;
    int         sl_ph   = 0;
    int         sl_cnt  = 0;
    logic [7:0] sl_byte = 8'h00;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (sl_mode == 1) begin
                m_ready = 1'b1;
                sl_ph   = 0;
            end else begin
                case (sl_ph)
                    0: if (m_enable) sl_ph = 1;
                    1: if (!m_enable) begin sl_cnt = 0; sl_ph = 2; end
                    2: begin
                        sl_cnt++;
                        if (sl_cnt >= 3) begin m_ready = 1'b0; sl_cnt = 0; sl_ph = 3; end
                    end
                    3: begin
                        sl_cnt++;
                        if (sl_mode == 0 && sl_cnt >= 10) begin
                            m_ready = 1'b1; m_data_out = sl_byte; sl_ph = 0;
                        end
                    end
                    default: sl_ph = 0;
                endcase
            end
        end
    end

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    // Model: a transaction is described by its grant cycle, the cycle the master
    // went busy and the cycle of its done/err pulse.
    bit         chk_en = 1'b0;
    bit         mb = 1'b0;
    int         m_win = 0, m_ptr = 0, t_g = 0, t_fall = -1, t_end = -1;
    logic [3:0] e_gnt = '0, e_done = '0, e_err = '0;
    logic [7:0] e_rd = '0, e_data = '0;
    logic [6:0] e_addr = '0;
    logic       e_busy = 0, e_rw = 0, e_en = 0;
    int         done_cnt [4] = '{0, 0, 0, 0};
    int         gq[$];
    logic [3:0] prev_gnt = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("done", 32'(done), 32'(e_done));
            check("err", 32'(err), 32'(e_err));
            check("rd_data", 32'(rd_data), 32'(e_rd));
            check("busy", 32'(busy), 32'(e_busy));
            check("m_addr", 32'(m_addr), 32'(e_addr));
            check("m_data_in", 32'(m_data_in), 32'(e_data));
            check("m_rw", 32'(m_rw), 32'(e_rw));
            check("m_enable", 32'(m_enable), 32'(e_en));
            for (int i = 0; i < NREQ; i++) if (done[i] === 1'b1) done_cnt[i]++;
            if (gnt != 4'b0 && prev_gnt == 4'b0) begin
                for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) gq.push_back(i);
            end
            prev_gnt = gnt;
        end
        if (rst) begin
            mb = 0; m_ptr = 0; t_end = -1; t_fall = -1;
            e_gnt = '0; e_done = '0; e_err = '0; e_rd = '0; e_busy = 0;
            e_addr = '0; e_data = '0; e_rw = 0; e_en = 0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            e_done = '0;
            e_err  = '0;
            if (mb && cyc == t_end) begin
                mb = 0; e_gnt = '0; e_busy = 0;
                m_ptr = (m_win + 1) % NREQ;
            end else if (!mb) begin
                if (m_ready && req != 4'b0) begin
                    m_win = rr_pick(req, m_ptr);
                    mb = 1; t_g = cyc + 1; t_fall = -1; t_end = -1;
                    e_gnt = 4'(1 << m_win); e_busy = 1;
                    e_addr = req_addr[7*m_win +: 7];
                    e_data = req_data[8*m_win +: 8];
                    e_rw   = req_rw[m_win];
                end
            end else if (t_end < 0 && cyc >= t_g + EN_CYCLES) begin
                if (t_fall < 0) begin
                    if (!m_ready) t_fall = cyc + 1;
                    else if (cyc + 1 - (t_g + EN_CYCLES) == START_TO) begin
                        t_end = cyc + 1; e_err = e_gnt;
                    end
                end else begin
                    if (m_ready) begin
                        t_end = cyc + 1; e_done = e_gnt;
                        if (e_rw) e_rd = m_data_out;
                    end else if (cyc + 1 - t_fall == XFER_TO) begin
                        t_end = cyc + 1; e_err = e_gnt;
                    end
                end
            end
            e_en = mb && (cyc + 1 - t_g < EN_CYCLES);
        end
    end

    task automatic nsync(); @(negedge clk); #1; endtask
    task automatic dsync(); @(posedge clk); #1; endtask

    task automatic do_reset();
        dsync(); rst = 1'b1; req = '0;
        dsync(); dsync(); rst = 1'b0;
    endtask

    // which: 0 done[idx], 1 err[idx], 2 gnt[idx], 3 any grant, 4 m_ready low, 5 idle
    task automatic wait_for(input string nm, input int which, input int idx, input int budget);
        int  k = 0;
        bit  hit = 0;
        while (k < budget) begin
            case (which)
                0: hit = done[idx];
                1: hit = err[idx];
                2: hit = gnt[idx];
                3: hit = (gnt != 4'b0);
                4: hit = !m_ready;
                default: hit = !busy;
            endcase
            if (hit) break;
            nsync(); k++;
        end
        if (!hit) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timed out after %0d cycles", nm, budget);
        end
    endtask

    initial begin
        int en, t0, base_q;
        int base_d [4];
        do_reset();

        // Single write
        req_addr[6:0] = 7'h2A; req_data[7:0] = 8'hAA; req_rw = 4'b0000; req = 4'b0001;
        nsync(); check("gnt_before", 32'(gnt), 32'h0);
        nsync(); check("gnt_write", 32'(gnt), 32'h1);
        check("m_addr_write", 32'(m_addr), 32'h2A);
        check("m_data_write", 32'(m_data_in), 32'hAA);
        en = 0;
        while (m_enable && en < 20) begin en++; nsync(); end
        check("enable_len", 32'(en), 32'd5);
        wait_for("done0", 0, 0, 200);
        check("rd_after_write", 32'(rd_data), 32'h00);
        dsync(); req = '0;

        // Read
        do_reset();
        sl_byte = 8'h5C;
        req_addr[20:14] = 7'h33; req_data[23:16] = 8'h11; req_rw = 4'b0100; req = 4'b0100;
        wait_for("done2", 0, 2, 200);
        check("rd_read", 32'(rd_data), 32'h5C);
        dsync(); req = '0;
        nsync(); check("gnt_cleared", 32'(gnt), 32'h0);

        // Round-robin with everyone requesting
        do_reset();
        sl_byte = 8'hA5;
        req_addr = {7'h44, 7'h33, 7'h22, 7'h11};
        req_data = {8'h04, 8'h03, 8'h02, 8'h01};
        req_rw = 4'b0101; req = 4'b1111;
        base_q = gq.size();
        for (int i = 0; i < NREQ; i++) base_d[i] = done_cnt[i];
        t0 = 0;
        while (gq.size() < base_q + 5 && t0 < 1000) begin nsync(); t0++; end
        check("rr_count", 32'(gq.size() - base_q), 32'd5);
        for (int i = 0; i < 5; i++)
            check("rr_order", 32'((gq.size() > base_q + i) ? gq[base_q + i] : -1), 32'(i % NREQ));
        for (int i = 0; i < NREQ; i++)
            check("rr_done_each", 32'(done_cnt[i] - base_d[i]), 32'd1);
        dsync(); req = '0;
        wait_for("rr_idle", 5, 0, 500);

        // Start timeout
        do_reset();
        sl_mode = 1;
        req_rw = 4'b0000; req = 4'b0010;
        wait_for("gnt1", 2, 1, 50);
        en = 0;
        while (m_enable && en < 20) begin en++; nsync(); end
        t0 = cyc;
        base_d[1] = done_cnt[1];
        wait_for("err1", 1, 1, 200);
        check("start_to_delay", 32'(cyc - t0), 32'(START_TO));
        dsync(); req = '0;
        nsync();
        check("start_to_gnt", 32'(gnt), 32'h0);
        check("start_to_busy", 32'(busy), 32'h0);
        check("start_to_nodone", 32'(done_cnt[1] - base_d[1]), 32'd0);
        sl_mode = 0;

        // Transfer timeout, then pointer advance
        do_reset();
        sl_mode = 2;
        req = 4'b0001;
        wait_for("gnt0", 2, 0, 50);
        wait_for("ready_low", 4, 0, 100);
        t0 = cyc;
        wait_for("err0", 1, 0, XFER_TO + 100);
        check("xfer_to_delay", 32'(cyc - t0), 32'(XFER_TO + 1));
        dsync(); req = '0; sl_mode = 0;
        dsync(); req = 4'b0011;
        wait_for("gnt_after_to", 3, 0, 100);
        check("ptr_advance", 32'(gnt), 32'h2);
        wait_for("done1", 0, 1, 200);
        dsync(); req = '0;

        // Reset during the transfer phase
        do_reset();
        req = 4'b0100;
        base_d[2] = done_cnt[2];
        wait_for("gnt2", 2, 2, 50);
        wait_for("ready_low2", 4, 0, 100);
        nsync();
        dsync(); rst = 1'b1; req = '0;
        dsync(); rst = 1'b0;
        nsync();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_enable", 32'(m_enable), 32'h0);
        dsync(); req_addr[27:21] = 7'h55; req = 4'b1000;
        wait_for("gnt_after_rst", 3, 0, 100);
        check("rst_winner", 32'(gnt), 32'h8);
        wait_for("done3", 0, 3, 200);
        dsync(); req = '0;
        check("rst_no_done2", 32'(done_cnt[2] - base_d[2]), 32'd0);
        wait_for("final_idle", 5, 0, 50);
        nsync();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
